// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: core vs debug loader.
// One transaction at a time, round-robin on conflict.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: RD_LAT must be 1..4");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state, state_nx;
  logic              last, last_nx;
  logic              win, win_nx;
  logic              we_q, we_nx;
  logic [ADDR_W-1:0] addr_q, addr_nx;
  logic [DATA_W-1:0] wdata_q, wdata_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [DATA_W-1:0] core_rd_q, core_rd_nx;
  logic [DATA_W-1:0] dbg_rd_q, dbg_rd_nx;
  logic              el_core, el_dbg, pick;

  // next-state: arbitration, latching and access sequencing
  always_comb begin
    state_nx   = state;
    last_nx    = last;
    win_nx     = win;
    we_nx      = we_q;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    cnt_nx     = cnt;
    core_rd_nx = core_rd_q;
    dbg_rd_nx  = dbg_rd_q;
    el_core    = core_req & ~dbg_lock;
    el_dbg     = dbg_req;
    pick       = (el_core & el_dbg) ? ~last : el_dbg;
    unique case (state)
      IDLE: begin
        if (el_core | el_dbg) begin
          win_nx   = pick;
          last_nx  = pick;
          we_nx    = pick ? dbg_we : core_we;
          addr_nx  = pick ? dbg_addr : core_addr;
          wdata_nx = pick ? dbg_wdata : core_wdata;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_nx = IDLE;
        end else begin
          cnt_nx   = CNT_INIT;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 2'd0) begin
          if (win == OWN_DBG) dbg_rd_nx = mem_rdata;
          else core_rd_nx = mem_rdata;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // state and latched transaction registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= OWN_DBG;
      win       <= OWN_CORE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= 2'd0;
      core_rd_q <= '0;
      dbg_rd_q  <= '0;
    end else begin
      state     <= state_nx;
      last      <= last_nx;
      win       <= win_nx;
      we_q      <= we_nx;
      addr_q    <= addr_nx;
      wdata_q   <= wdata_nx;
      cnt       <= cnt_nx;
      core_rd_q <= core_rd_nx;
      dbg_rd_q  <= dbg_rd_nx;
    end
  end

  assign mem_en      = (state == ISSUE);
  assign mem_we      = mem_en & we_q;
  assign mem_addr    = mem_en ? addr_q : '0;
  assign mem_wdata   = mem_en ? wdata_q : '0;
  assign core_gnt    = mem_en & (win == OWN_CORE);
  assign dbg_gnt     = mem_en & (win == OWN_DBG);
  assign core_rvalid = (state == RESP) & (win == OWN_CORE);
  assign dbg_rvalid  = (state == RESP) & (win == OWN_DBG);
  assign core_rdata  = core_rd_q;
  assign dbg_rdata   = dbg_rd_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline model,
// memory responder and directed scenarios.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] core_addr, dbg_addr, mem_addr;
  logic [DW-1:0] core_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic [DW-1:0] core_rdata, dbg_rdata;
  logic          core_gnt, core_rvalid, dbg_gnt, dbg_rvalid;
  logic          mem_en, mem_we, busy;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  int ecount = 0;

  // memory macro: writes on mem_en, read data valid LAT cycles later
  logic [DW-1:0] mem [64];
  int            rd_due = -1;
  logic [5:0]    rd_idx;
  always @(negedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
      else begin
        rd_due = ecount + LAT;
        rd_idx = mem_addr[7:2];
      end
    end
    if (rd_due == ecount) mem_rdata = mem[rd_idx];
    else mem_rdata = 32'hBAD0_0000 ^ 32'(ecount);
  end

  // reference model: a transaction is a timeline relative to its sample edge
  localparam bit CORE = 1'b0;
  localparam bit DBG  = 1'b1;
  logic [DW-1:0] ref_mem [64];
  bit            m_act, m_win, m_we, m_last, el_c, el_d;
  int            m_start, m_len;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd, exp_crd, exp_drd;

  always @(posedge clk) begin
    ecount++;
    if (reset !== 1'b1) begin
      m_act   = 1'b0;
      m_last  = DBG;
      exp_crd = '0;
      exp_drd = '0;
    end else begin
      if (m_act && (ecount - m_start >= m_len)) m_act = 1'b0;
      if (!m_act) begin
        el_c = core_req && !dbg_lock;
        el_d = dbg_req;
        if (el_c || el_d) begin
          if (el_c && el_d) m_win = (m_last == DBG) ? CORE : DBG;
          else m_win = el_d ? DBG : CORE;
          m_last  = m_win;
          m_act   = 1'b1;
          m_start = ecount;
          m_we    = (m_win == DBG) ? dbg_we : core_we;
          m_addr  = (m_win == DBG) ? dbg_addr : core_addr;
          m_wdata = (m_win == DBG) ? dbg_wdata : core_wdata;
          m_len   = m_we ? 2 : LAT + 3;
          if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
          else m_rd = ref_mem[m_addr[7:2]];
        end
      end
      if (m_act && !m_we && (ecount - m_start == m_len - 2)) begin
        if (m_win == DBG) exp_drd = m_rd;
        else exp_crd = m_rd;
      end
    end
  end

  int p;
  bit e_iss, e_rsp, e_busy;
  // per-cycle compare of every output against the model
  always @(negedge clk) begin
    if (ecount > 0) begin
      p      = ecount - m_start;
      e_iss  = m_act && (p == 0);
      e_rsp  = m_act && !m_we && (p == m_len - 2);
      e_busy = m_act && (p < m_len - 1);
      chk("busy", 64'(busy), 64'(e_busy));
      chk("mem_en", 64'(mem_en), 64'(e_iss));
      chk("core_gnt", 64'(core_gnt), 64'(e_iss && m_win == CORE));
      chk("dbg_gnt", 64'(dbg_gnt), 64'(e_iss && m_win == DBG));
      chk("core_rvalid", 64'(core_rvalid), 64'(e_rsp && m_win == CORE));
      chk("dbg_rvalid", 64'(dbg_rvalid), 64'(e_rsp && m_win == DBG));
      chk("core_rdata", 64'(core_rdata), 64'(exp_crd));
      chk("dbg_rdata", 64'(dbg_rdata), 64'(exp_drd));
      if (e_iss) begin
        chk("mem_we", 64'(mem_we), 64'(m_we));
        chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
      end
    end
  end

  task automatic wait_any(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(core_gnt || dbg_gnt) && n < 40);
    chk(name, 64'(core_gnt || dbg_gnt), 64'd1);
  endtask

  int            gcyc [4];
  bit            gwho [4];
  int            ng, nd, nc, rv, nw, idx;
  logic [AW-1:0] wa [8];
  logic [DW-1:0] wd [8];

  initial begin
    reset = 1'b0; dbg_lock = 1'b0; mem_rdata = '0;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[16]     = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    // 1: reset held with both requesting
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h84; dbg_wdata = 32'h22;
    repeat (3) @(negedge clk);
    chk("t1_rst_busy", 64'(busy), 64'd0);
    chk("t1_rst_gnt", 64'(core_gnt | dbg_gnt), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("t1_core_gnt", 64'(core_gnt), 64'd1);
    chk("t1_dbg_gnt", 64'(dbg_gnt), 64'd0);
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(negedge clk);

    // 2: core read of 0x40
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    @(negedge clk);
    chk("t2_gnt", 64'(core_gnt), 64'd1);
    chk("t2_mem_en", 64'(mem_en), 64'd1);
    chk("t2_addr", 64'(mem_addr), 64'h40);
    core_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("t2_early_rvalid", 64'(core_rvalid), 64'd0);
    @(negedge clk);
    chk("t2_rvalid", 64'(core_rvalid), 64'd1);
    chk("t2_rdata", 64'(core_rdata), 64'hDEAD_BEEF);
    repeat (2) @(negedge clk);

    // single dbg write leaves the loader as last owner
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h88; dbg_wdata = 32'h33;
    wait_any("tx_dbg_gnt");
    dbg_req = 1'b0;
    repeat (2) @(negedge clk);

    // 3: both writing continuously -> alternation
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h80; core_wdata = 32'hA1;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h84; dbg_wdata = 32'hB1;
    ng = 0;
    for (int c = 1; c <= 12 && ng < 4; c++) begin
      @(negedge clk);
      if (core_gnt || dbg_gnt) begin
        gwho[ng] = dbg_gnt;
        gcyc[ng] = c;
        ng++;
      end
    end
    core_req = 1'b0; dbg_req = 1'b0;
    chk("t3_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) chk("t3_order", 64'(gwho[i]), 64'(i % 2));
    for (int i = 1; i < 4; i++) chk("t3_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd2);
    repeat (2) @(negedge clk);

    // 4: lock keeps the core out
    dbg_lock = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h40;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
    nd = 0; nc = 0;
    for (int c = 0; c < 40 && nd < 4; c++) begin
      @(negedge clk);
      if (dbg_gnt) nd++;
      if (core_gnt) nc++;
    end
    dbg_lock = 1'b0;
    chk("t4_dbg_gnts", 64'(nd), 64'd4);
    chk("t4_core_gnts", 64'(nc), 64'd0);
    wait_any("t4_unlock_gnt");
    chk("t4_core_next", 64'(core_gnt), 64'd1);
    core_req = 1'b0; dbg_req = 1'b0;
    repeat (6) @(negedge clk);

    // 5: reset during a dbg read wait
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h48;
    wait_any("t5_gnt");
    chk("t5_dbg_gnt", 64'(dbg_gnt), 64'd1);
    dbg_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_dbg_rdata", 64'(dbg_rdata), 64'd0);
    chk("t5_core_rdata", 64'(core_rdata), 64'd0);
    reset = 1'b1;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (dbg_rvalid) rv++;
    end
    chk("t5_no_rvalid", 64'(rv), 64'd0);

    // 6: back-to-back core writes
    core_req = 1'b1; core_we = 1'b1; core_addr = 32'h0; core_wdata = 32'd1;
    idx = 0; nw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_we) begin
        if (nw < 8) begin
          wa[nw] = mem_addr;
          wd[nw] = mem_wdata;
        end
        nw++;
      end
      if (core_gnt) begin
        if (idx < 3) begin
          idx++;
          core_addr  = 32'(4 * idx);
          core_wdata = 32'(idx + 1);
        end else core_req = 1'b0;
      end
    end
    chk("t6_we_cycles", 64'(nw), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t6_addr", 64'(wa[i]), 64'(4 * i));
      chk("t6_data", 64'(wd[i]), 64'(i + 1));
    end

    // loader reads back one of those words
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8;
    wait_any("rb_gnt");
    dbg_req = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    chk("rb_rvalid", 64'(dbg_rvalid), 64'd1);
    chk("rb_rdata", 64'(dbg_rdata), 64'd3);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
